// File: rtl/fpu_div_responder_pkg.sv
// Shared types and constants for the floating-point divide responder.
package fpu_pkg;
    localparam int FP_W   = 64;
    localparam int FLAG_W = 5;
    localparam int CNT_W  = 8;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RDN = 2'b10;
    localparam logic [1:0] RM_RUP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_RESP
    } div_rsp_state_t;

    // The divider leaves the upper word undefined in single precision.
    function automatic logic [FP_W-1:0] fmt_result(input logic db, input logic [FP_W-1:0] r);
        return db ? r : {32'h0, r[31:0]};
    endfunction
endpackage

// File: rtl/fpu_div_responder_if.sv
// Request/response channel between a consumer and the divide responder.
interface fpu_div_responder_if;
    import fpu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [FP_W-1:0]   req_a;
    logic [FP_W-1:0]   req_b;
    logic              req_db;
    logic [1:0]        req_rm;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [FP_W-1:0]   rsp_result;
    logic [FLAG_W-1:0] rsp_flags;

    modport slave (
        input  req_valid, req_a, req_b, req_db, req_rm, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags
    );

    modport master (
        output req_valid, req_a, req_b, req_db, req_rm, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags
    );
endinterface

// File: rtl/fpu_div_responder_counter.sv
// Loadable 8-bit down-counter with zero flag; saturates at zero.
module fpu_latency_counter
    import fpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/fpu_div_responder.sv
// Valid/ready front end for the iterative FP divider: clear, wait fixed latency,
// capture and hold the result until consumed.
module fpu_div_responder
    import fpu_pkg::*;
#(
    parameter int DIV_LATENCY = 21,
    parameter int CLR_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    fpu_div_responder_if.slave bus,
    output logic              div_rst_n,
    output logic [FP_W-1:0]   div_fpa,
    output logic [FP_W-1:0]   div_fpb,
    output logic              div_db,
    output logic [1:0]        div_rm,
    output logic              div_fdiv,
    output logic              div_normal,
    output logic              div_sub,
    input  logic [FP_W-1:0]   div_result,
    input  logic [FLAG_W-1:0] div_flags
);
    localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LOAD = CNT_W'(DIV_LATENCY - 1);

    div_rsp_state_t    state_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [FP_W-1:0]   rsp_result_q;
    logic [FLAG_W-1:0] rsp_flags_q;
    logic              div_rst_n_q;
    logic [FP_W-1:0]   fpa_q;
    logic [FP_W-1:0]   fpb_q;
    logic              db_q;
    logic [1:0]        rm_q;
    logic              mode_q;

    logic              req_hs;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_zero;

    assign req_hs       = bus.req_valid && req_ready_q;
    assign cnt_load     = ((state_q == ST_IDLE) && req_hs) || ((state_q == ST_CLEAR) && cnt_zero);
    assign cnt_load_val = (state_q == ST_IDLE) ? CLR_LOAD : RUN_LOAD;

    fpu_latency_counter u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            div_rst_n_q  <= 1'b0;
            fpa_q        <= '0;
            fpb_q        <= '0;
            db_q         <= 1'b0;
            rm_q         <= '0;
            mode_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_hs) begin
                        fpa_q       <= bus.req_a;
                        fpb_q       <= bus.req_b;
                        db_q        <= bus.req_db;
                        rm_q        <= bus.req_rm;
                        mode_q      <= 1'b1;
                        req_ready_q <= 1'b0;
                        div_rst_n_q <= 1'b0;
                        state_q     <= ST_CLEAR;
                    end else begin
                        req_ready_q <= 1'b1;
                        div_rst_n_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_zero) begin
                        div_rst_n_q <= 1'b1;
                        state_q     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt_zero) begin
                        rsp_result_q <= fmt_result(db_q, div_result);
                        rsp_flags_q  <= div_flags;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        mode_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign div_rst_n      = div_rst_n_q;
    assign div_fpa        = fpa_q;
    assign div_fpb        = fpb_q;
    assign div_db         = db_q;
    assign div_rm         = rm_q;
    assign div_fdiv       = mode_q;
    assign div_normal     = mode_q;
    assign div_sub        = 1'b0;
endmodule
